inst_fetch: RTL and testbench



---
 rtl/inst_fetch_pkg.sv | 28 ++
 rtl/inst_fetch_assembler.sv | 54 +++++
 rtl/inst_fetch.sv | 97 +++++++++
 tb/tb_inst_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared bus widths, control encodings and fetch FSM states for the
// byte-serial instruction fetch stage.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NotStop   = 1'b0;
  localparam logic Branch    = 1'b1;

  localparam logic [InstAddrBus-1:0] ZeroWord = '0;

  typedef enum logic {
    FETCH = 1'b0,
    READY = 1'b1
  } FetchState;

  // Byte address of the offset-th byte of an instruction; wraps at 2^32.
  function automatic logic [InstAddrBus-1:0] byteAddr(
    input logic [InstAddrBus-1:0] base,
    input logic [2:0]             offset
  );
    return base + InstAddrBus'(offset);
  endfunction

endpackage

// File: rtl/inst_fetch_assembler.sv
// Collects RAM bytes into a little-endian instruction word. A byte is taken
// the cycle after its read was issued, tracked by the pending flag.
module inst_fetch_assembler
  import inst_fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               issue_i,
  input  logic [7:0]         din_i,
  output logic [InstBus-1:0] word_o,
  output logic               complete_o
);

  logic [23:0] lanes_q, lanes_d;
  logic [2:0]  rcv_q, rcv_d;
  logic        pending_q, pending_d;

  always_comb begin
    lanes_d   = lanes_q;
    rcv_d     = rcv_q;
    pending_d = pending_q;
    if (clear_i) begin
      rcv_d     = '0;
      pending_d = 1'b0;
    end else begin
      pending_d = issue_i;
      if (pending_q) begin
        if (rcv_q < 3'd3) begin
          lanes_d[{rcv_q[1:0], 3'b000} +: 8] = din_i;
        end
        rcv_d = rcv_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RstEnable) begin
      lanes_q   <= '0;
      rcv_q     <= '0;
      pending_q <= 1'b0;
    end else if (en_i) begin
      lanes_q   <= lanes_d;
      rcv_q     <= rcv_d;
      pending_q <= pending_d;
    end
  end

  // The top byte is never stored: it is consumed straight from the RAM bus.
  assign word_o     = {din_i, lanes_q};
  assign complete_o = pending_q && (rcv_q == 3'd3);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: reads four bytes over a shared 8-bit RAM port and
// presents the assembled instruction until the pipeline accepts it.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [5:0]             stall,
  input  logic                   branch_flag_in,
  input  logic [InstAddrBus-1:0] branch_target_in,
  input  logic                   mem_grant_in,
  input  logic [7:0]             mem_din_in,
  output logic [InstAddrBus-1:0] mem_a_out,
  output logic                   mem_rd_out,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   stallreq_out
);

  FetchState              state_q;
  logic [InstAddrBus-1:0] pc_q;
  logic [2:0]             iss_q;
  logic [InstAddrBus-1:0] ifPc_q;
  logic [InstBus-1:0]     ifInst_q;

  logic               issue;
  logic               branchTaken;
  logic               consume;
  logic               asmComplete;
  logic [InstBus-1:0] asmWord;
  logic               unusedStallBits;

  assign unusedStallBits = ^stall[5:2];

  assign branchTaken = (branch_flag_in == Branch);
  assign consume     = (state_q == READY) && (stall[0] == NotStop) && (stall[1] == NotStop);

  // A branch cycle issues nothing, since any byte it returned would be thrown away.
  assign issue = rdy_in && !rst_in && (state_q == FETCH) && !branchTaken &&
                 mem_grant_in && (iss_q != 3'd4);

  assign mem_rd_out   = issue;
  assign mem_a_out    = issue ? byteAddr(pc_q, iss_q) : ZeroWord;
  assign if_pc        = ifPc_q;
  assign if_inst      = ifInst_q;
  assign stallreq_out = (state_q == FETCH);

  inst_fetch_assembler u_assembler (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .en_i       (rdy_in),
    .clear_i    (branchTaken || consume),
    .issue_i    (issue),
    .din_i      (mem_din_in),
    .word_o     (asmWord),
    .complete_o (asmComplete)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RstEnable) begin
      state_q  <= FETCH;
      pc_q     <= ZeroWord;
      iss_q    <= '0;
      ifPc_q   <= ZeroWord;
      ifInst_q <= '0;
    end else if (rdy_in) begin
      if (branchTaken) begin
        state_q <= FETCH;
        pc_q    <= branch_target_in;
        iss_q   <= '0;
      end else begin
        case (state_q)
          FETCH: begin
            if (issue) begin
              iss_q <= iss_q + 3'd1;
            end
            if (asmComplete) begin
              state_q  <= READY;
              ifPc_q   <= pc_q;
              ifInst_q <= asmWord;
            end
          end
          READY: begin
            if (consume) begin
              state_q <= FETCH;
              pc_q    <= pc_q + InstAddrBus'(4);
              iss_q   <= '0;
            end
          end
          default: state_q <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a RAM model answers reads, the driver
// queues expected instructions, the monitor checks each one presented.
module tb_inst_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [5:0]  stall = '0;
  logic        branch_flag_in = 1'b0;
  logic [31:0] branch_target_in = '0;
  logic        mem_grant_in = 1'b0;
  logic [7:0]  mem_din_in = '0;
  logic [31:0] mem_a_out;
  logic        mem_rd_out;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_out;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } Expect;

  Expect       expQ[$];
  logic [31:0] issuedQ[$];
  logic [7:0]  ramOverride[logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  logic        lastRd = 1'b0;
  logic [31:0] lastAddr = '0;
  logic        sRd;
  logic [31:0] sAddr;
  logic        sStallreq;
  logic [31:0] modelPc = '0;
  bit          monitorOn = 1'b0;
  logic        prevStall = 1'b1;
  bit          heldValid = 1'b0;
  Expect       held;

  inst_fetch dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .stall            (stall),
    .branch_flag_in   (branch_flag_in),
    .branch_target_in (branch_target_in),
    .mem_grant_in     (mem_grant_in),
    .mem_din_in       (mem_din_in),
    .mem_a_out        (mem_a_out),
    .mem_rd_out       (mem_rd_out),
    .if_pc            (if_pc),
    .if_inst          (if_inst),
    .stallreq_out     (stallreq_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ramByte(input logic [31:0] a);
    if (ramOverride.exists(a)) return ramOverride[a];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic Expect fetchWord(input logic [31:0] a);
    Expect e;
    e.pc   = a;
    e.inst = {ramByte(a + 32'd3), ramByte(a + 32'd2), ramByte(a + 32'd1), ramByte(a)};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, let the RAM answer last cycle's read, sample, update the model.
  task automatic applyStimulus(input logic grant, input logic [5:0] stallV, input logic br,
                               input logic [31:0] target, input logic rdy);
    @(posedge clk_in);
    #1;
    rst_in           = 1'b0;
    mem_grant_in     = grant;
    stall            = stallV;
    branch_flag_in   = br;
    branch_target_in = target;
    rdy_in           = rdy;
    if (lastRd) mem_din_in = ramByte(lastAddr);
    @(negedge clk_in);
    #1;
    sRd       = mem_rd_out;
    sAddr     = mem_a_out;
    sStallreq = stallreq_out;
    lastRd    = sRd;
    lastAddr  = sAddr;
    if (sRd) issuedQ.push_back(sAddr);
    if (!rdy) checkOutput("rdyLowNoRead", {31'b0, sRd}, 32'd0);
    if (rdy) begin
      if (br) begin
        expQ.delete();
        modelPc = target;
        expQ.push_back(fetchWord(modelPc));
      end else if (!sStallreq && stallV[1:0] == 2'b00) begin
        modelPc = modelPc + 32'd4;
        expQ.push_back(fetchWord(modelPc));
      end
    end
  endtask

  task automatic doReset();
    @(posedge clk_in);
    #1;
    rst_in         = 1'b1;
    branch_flag_in = 1'b0;
    rdy_in         = 1'b1;
    mem_grant_in   = 1'b1;
    stall          = '0;
    #1;
    checkOutput("rstIfPc", if_pc, 32'd0);
    checkOutput("rstIfInst", if_inst, 32'd0);
    checkOutput("rstStallreq", {31'b0, stallreq_out}, 32'd1);
    checkOutput("rstRd", {31'b0, mem_rd_out}, 32'd0);
    checkOutput("rstAddr", mem_a_out, 32'd0);
    expQ.delete();
    modelPc = '0;
    expQ.push_back(fetchWord(32'd0));
    lastRd = 1'b0;
    repeat (2) @(posedge clk_in);
  endtask

  // Runs until an instruction is presented; n counts the cycles stallreq_out stayed high.
  task automatic runFetch(input logic [5:0] stallV, input int lowA, input int lowB, output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(!(i == lowA || i == lowB), stallV, 1'b0, 32'd0, 1'b1);
      if (!sStallreq) break;
      n++;
    end
    if (sStallreq) begin
      checks++;
      errors++;
      $display("[TB] FAIL fetchTimeout: got no instruction after %0d cycles, expected one", n);
    end
  endtask

  task automatic checkIssued(input logic [31:0] base);
    checkOutput("issueCount", issuedQ.size(), 32'd4);
    for (int i = 0; i < 4 && i < issuedQ.size(); i++) begin
      checkOutput("issueAddr", issuedQ[i], base + i);
    end
  endtask

  initial begin : monitor
    Expect e;
    forever begin
      @(negedge clk_in);
      if (monitorOn) begin
        if (!mem_rd_out) checkOutput("idleAddrZero", mem_a_out, 32'd0);
        if (!stallreq_out) begin
          checkOutput("readyNoRead", {31'b0, mem_rd_out}, 32'd0);
          if (prevStall) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              heldValid = 1'b0;
              $display("[TB] FAIL unexpectedPresent: got pc 0x%08h, expected no instruction", if_pc);
            end else begin
              e = expQ.pop_front();
              held = e;
              heldValid = 1'b1;
              checkOutput("presentPc", if_pc, e.pc);
              checkOutput("presentInst", if_inst, e.inst);
            end
          end else if (heldValid) begin
            checkOutput("heldPc", if_pc, held.pc);
            checkOutput("heldInst", if_inst, held.inst);
          end
        end
      end
      prevStall = stallreq_out;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int          n;
    logic        rdy;
    logic        gr;
    logic        br;
    logic [5:0]  sv;
    logic [31:0] tg;

    ramOverride[32'd0] = 8'h13;
    ramOverride[32'd1] = 8'h05;
    ramOverride[32'd2] = 8'h10;
    ramOverride[32'd3] = 8'h00;

    doReset();
    monitorOn = 1'b1;
    issuedQ.delete();
    runFetch(6'h02, -1, -1, n);
    checkOutput("firstLatency", n, 32'd5);
    checkIssued(32'd0);
    checkOutput("firstInst", if_inst, 32'h00100513);
    checkOutput("firstPc", if_pc, 32'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 6'h02, 1'b0, 32'd0, 1'b1);
      checkOutput("stallHoldsReady", {31'b0, sStallreq}, 32'd0);
      checkOutput("stallNoRead", {31'b0, sRd}, 32'd0);
    end
    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b1);
    issuedQ.delete();
    runFetch(6'h02, 1, 2, n);
    checkOutput("grantGapLatency", n, 32'd7);
    checkIssued(32'd4);

    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 6'h00, 1'b1, 32'h0000_1000, 1'b1);
    issuedQ.delete();
    runFetch(6'h02, -1, -1, n);
    checkOutput("branchLatency", n, 32'd5);
    checkIssued(32'h0000_1000);
    checkOutput("branchIfPc", if_pc, 32'h0000_1000);

    applyStimulus(1'b1, 6'h02, 1'b1, 32'hFFFF_FFFE, 1'b1);
    issuedQ.delete();
    runFetch(6'h02, -1, -1, n);
    checkOutput("wrapLatency", n, 32'd5);
    checkIssued(32'hFFFF_FFFE);

    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 6'h00, 1'b0, 32'd0, 1'b1);
    doReset();
    issuedQ.delete();
    runFetch(6'h02, -1, -1, n);
    checkOutput("restartLatency", n, 32'd5);
    checkIssued(32'd0);

    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(9) != 0);
      gr  = ($urandom_range(3) != 0);
      sv  = ($urandom_range(2) == 0) ? 6'($urandom) : 6'h00;
      br  = rdy && ($urandom_range(24) == 0);
      tg  = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3))) : $urandom;
      applyStimulus(gr, sv, br, tg, rdy);
    end

    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 6'h3F, 1'b0, 32'd0, 1'b1);
    end
    checkOutput("drainEmpty", expQ.size(), 32'd0);
    monitorOn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
